// File: rtl/eth_rx_framer.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_framer
// Purpose  : GMII receive framer. Strips preamble/SFD, streams DA..last
//            payload byte through a 5-byte delay line so the 4 FCS bytes
//            are never presented, checks CRC-32, length and RX error, and
//            keeps good/bad frame counters.
// Ports    : clkIn        - 125 MHz RX fabric clock (rising edge only)
//            rstBIn       - asynchronous active-low reset
//            rxDvIn       - GMII data valid
//            rxErIn       - GMII receive error
//            rxDataIn     - GMII receive byte
//            dataOut      - payload byte
//            validOut     - dataOut qualifier
//            lastOut      - final payload byte marker
//            frameGoodOut - frame status, meaningful with lastOut
//            goodCntOut   - frames reported good (wrapping)
//            badCntOut    - frames reported bad or discarded (wrapping)
// Revision : 1.0 - initial release
// ============================================================================
module eth_rx_framer #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clkIn,
  input  logic        rstBIn,
  input  logic        rxDvIn,
  input  logic        rxErIn,
  input  logic [7:0]  rxDataIn,
  output logic [7:0]  dataOut,
  output logic        validOut,
  output logic        lastOut,
  output logic        frameGoodOut,
  output logic [15:0] goodCntOut,
  output logic [15:0] badCntOut
);

  localparam logic [31:0] c_CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] c_CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] c_CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [7:0]  c_PRE_BYTE    = 8'h55;
  localparam logic [7:0]  c_SFD_BYTE    = 8'hD5;
  localparam logic [10:0] c_CNT_MAX     = 11'd2047;
  localparam logic [2:0]  c_DLY_DEPTH   = 3'd5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_crc;
  logic [10:0] r_byteCnt;
  logic        r_err;
  // Delay line: newest byte in [7:0], oldest in [39:32].
  logic [39:0] r_dly;
  logic [2:0]  r_held;

  logic [31:0] w_crcNext;
  logic        w_lenOk;
  logic        w_frameGood;
  logic        w_dlyFull;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crcByte(input logic [31:0] crcIn,
                                          input logic [7:0]  dIn);
    logic [31:0] c;
    c = crcIn ^ {24'd0, dIn};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ c_CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign w_crcNext   = crcByte(r_crc, rxDataIn);
  assign w_lenOk     = ({21'd0, r_byteCnt} >= MIN_LEN) &&
                       ({21'd0, r_byteCnt} <= MAX_LEN);
  // Running the CRC over the FCS as well leaves the fixed residue when intact.
  assign w_frameGood = (r_crc == c_CRC_RESIDUE) && !r_err && w_lenOk;
  // A full delay line is equivalent to having seen at least 5 DATA bytes.
  assign w_dlyFull   = (r_held == c_DLY_DEPTH);

  always_ff @(posedge clkIn or negedge rstBIn) begin
    if (!rstBIn) begin
      r_state      <= IDLE;
      r_crc        <= c_CRC_INIT;
      r_byteCnt    <= 11'd0;
      r_err        <= 1'b0;
      r_dly        <= 40'd0;
      r_held       <= 3'd0;
      dataOut      <= 8'h00;
      validOut     <= 1'b0;
      lastOut      <= 1'b0;
      frameGoodOut <= 1'b0;
      goodCntOut   <= 16'd0;
      badCntOut    <= 16'd0;
    end else begin
      validOut     <= 1'b0;
      lastOut      <= 1'b0;
      frameGoodOut <= 1'b0;

      case (r_state)
        IDLE: begin
          if (rxDvIn) begin
            r_state <= (rxDataIn == c_PRE_BYTE) ? PREAMBLE : DROP;
          end
        end

        PREAMBLE: begin
          if (!rxDvIn) begin
            r_state <= IDLE;
          end else if (rxDataIn == c_SFD_BYTE) begin
            r_state   <= DATA;
            r_crc     <= c_CRC_INIT;
            r_byteCnt <= 11'd0;
            r_err     <= 1'b0;
            r_held    <= 3'd0;
          end else if (rxDataIn != c_PRE_BYTE) begin
            r_state <= DROP;
          end
        end

        DATA: begin
          if (rxDvIn) begin
            r_crc <= w_crcNext;
            if (r_byteCnt != c_CNT_MAX) begin
              r_byteCnt <= r_byteCnt + 11'd1;
            end
            if (rxErIn) begin
              r_err <= 1'b1;
            end
            r_dly <= {r_dly[31:0], rxDataIn};
            if (w_dlyFull) begin
              dataOut  <= r_dly[39:32];
              validOut <= 1'b1;
            end else begin
              r_held <= r_held + 3'd1;
            end
          end else begin
            // Frame end: the oldest held byte is the last payload byte; the
            // other four held bytes are the FCS and are simply flushed.
            r_state <= IDLE;
            r_held  <= 3'd0;
            if (w_dlyFull) begin
              dataOut      <= r_dly[39:32];
              validOut     <= 1'b1;
              lastOut      <= 1'b1;
              frameGoodOut <= w_frameGood;
              if (w_frameGood) begin
                goodCntOut <= goodCntOut + 16'd1;
              end else begin
                badCntOut <= badCntOut + 16'd1;
              end
            end else begin
              badCntOut <= badCntOut + 16'd1;
            end
          end
        end

        DROP: begin
          if (!rxDvIn) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
